// File: rtl/dma_stream_arbiter_if.sv
// Handshake bundle between the DMA stream arbiter and its surroundings:
// per-stream requests and priorities in, grant and config-load strobe out.
interface dma_stream_arbiter_if #(
  parameter int NSTREAMS = 8,
  parameter int IDW      = 3
);
  logic [NSTREAMS-1:0]   i_req;
  logic [2*NSTREAMS-1:0] i_pl;
  logic                  i_abort;
  logic                  i_unit_done;
  logic [NSTREAMS-1:0]   o_grant;
  logic [IDW-1:0]        o_grant_id;
  logic                  o_grant_valid;
  logic                  o_load;
  logic                  o_busy;

  modport slave (
    input  i_req, i_pl, i_abort, i_unit_done,
    output o_grant, o_grant_id, o_grant_valid, o_load, o_busy
  );

  modport master (
    output i_req, i_pl, i_abort, i_unit_done,
    input  o_grant, o_grant_id, o_grant_valid, o_load, o_busy
  );
endinterface

// File: rtl/dma_stream_arbiter.sv
// Grants the shared DMA transfer datapath to one stream at a time, chosen by
// priority level, and holds the grant until the unit completes or aborts.
module dma_stream_arbiter #(
  parameter int NSTREAMS = 8,
  parameter int IDW      = 3,
  parameter int RR_EQUAL = 0
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  dma_stream_arbiter_if.slave  bus
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_LOAD    = 2'd1;
  localparam logic [1:0] ST_ACTIVE  = 2'd2;
  localparam logic [1:0] ST_RELEASE = 2'd3;

  logic [1:0]     state_q, state_d;
  logic [IDW-1:0] id_q, id_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;

  logic [1:0]     pl_arr [NSTREAMS];
  logic [1:0]     top_pl;
  logic [IDW-1:0] win_id;
  logic [IDW-1:0] scan_id;
  logic           found;
  int             start;

  // Winner: highest level among requesters, ties broken by a scan that
  // starts at 0 or just after the last granted stream.
  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    top_pl  = '0;
    win_id  = '0;
    scan_id = '0;
    found   = 1'b0;
    start   = (RR_EQUAL != 0) ? int'(rr_ptr_q) + 1 : 0;
    for (int k = 0; k < NSTREAMS; k++) begin
      pl_arr[k] = bus.i_pl[2*k +: 2];
      if (bus.i_req[k] && (pl_arr[k] > top_pl)) top_pl = pl_arr[k];
    end
    for (int off = 0; off < NSTREAMS; off++) begin
      scan_id = IDW'((start + off) % NSTREAMS);
      if (!found && bus.i_req[scan_id] && (pl_arr[scan_id] == top_pl)) begin
        win_id = scan_id;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (|bus.i_req) begin
          id_d    = win_id;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD:   state_d = bus.i_abort ? ST_RELEASE : ST_ACTIVE;
      ST_ACTIVE: if (bus.i_unit_done || bus.i_abort) state_d = ST_RELEASE;
      ST_RELEASE: begin
        rr_ptr_d = id_q;
        state_d  = ST_IDLE;
      end
      default:   state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= ST_IDLE;
      id_q     <= '0;
      rr_ptr_q <= IDW'(NSTREAMS - 1);
    end else begin
      state_q  <= state_d;
      id_q     <= id_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign bus.o_grant_valid = (state_q == ST_LOAD) || (state_q == ST_ACTIVE);
  assign bus.o_grant       = bus.o_grant_valid ? (NSTREAMS'(1) << id_q) : '0;
  assign bus.o_grant_id    = id_q;
  assign bus.o_load        = (state_q == ST_LOAD);
  assign bus.o_busy        = (state_q != ST_IDLE);

endmodule
